// File: rtl/vga_frame_writer.sv
// vga_frame_writer: packs CPU-written Avalon bytes into 24-bit RGB pixels in a FIFO
// and streams them out under a free-running VGA timing generator.
module vga_frame_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic        address,
    input  logic        read,
    output logic [23:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        active
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, STREAM = 2'd2} state_t;

    state_t        r_state, w_state_nx;
    logic [11:0]   r_h, r_v;
    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic [1:0]    r_phase;
    logic [7:0]    r_r, r_g;
    logic          r_en, r_ufl, r_ovf;

    logic w_wr, w_rd, w_byte, w_ctl, w_flush, w_clr, w_full, w_empty;
    logic w_last_byte, w_push, w_drop, w_h_end, w_frame_end, w_act, w_slot, w_pop;
    logic w_unused;

    assign w_wr        = chipselect & write;
    assign w_rd        = chipselect & read & ~write;
    assign w_byte      = w_wr & ~address;
    assign w_ctl       = w_wr & address;
    assign w_flush     = w_ctl & writedata[2];
    assign w_clr       = w_ctl & writedata[1];
    assign w_full      = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_cnt == '0;
    assign w_last_byte = w_byte & (r_phase == 2'd2);
    assign w_push      = w_last_byte & ~w_full;
    assign w_drop      = w_last_byte & w_full;
    assign w_h_end     = r_h == 12'(H_TOTAL - 1);
    // State changes on the last clock of a frame so a new state owns the whole next frame.
    assign w_frame_end = w_h_end & (r_v == 12'(V_TOTAL - 1));
    assign w_act       = (r_h < 12'(H_ACTIVE)) & (r_v < 12'(V_ACTIVE));
    assign w_slot      = (r_state == STREAM) & w_act;
    assign w_pop       = w_slot & ~w_empty;
    assign w_unused    = &writedata[7:3];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = r_en ? ARMED : IDLE;
            ARMED:   w_state_nx = !r_en ? IDLE : (w_frame_end ? STREAM : ARMED);
            STREAM:  w_state_nx = (w_frame_end && !r_en) ? IDLE : STREAM;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_h      <= '0;
            r_v      <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_r      <= '0;
            r_g      <= '0;
            r_en     <= 1'b0;
            r_ufl    <= 1'b0;
            r_ovf    <= 1'b0;
            VGA_R    <= '0;
            VGA_G    <= '0;
            VGA_B    <= '0;
            HSYNC    <= 1'b1;
            VSYNC    <= 1'b1;
            active   <= 1'b0;
            readdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_h     <= w_h_end ? '0 : r_h + 12'd1;
            if (w_h_end)
                r_v <= (r_v == 12'(V_TOTAL - 1)) ? '0 : r_v + 12'd1;
            if (w_ctl)
                r_en <= writedata[0];
            r_ufl <= (r_ufl & ~w_clr) | (w_slot & w_empty);
            r_ovf <= (r_ovf & ~w_clr) | w_drop;
            if (w_flush)
                r_phase <= '0;
            else if (w_byte)
                r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            if (w_byte && r_phase == 2'd0)
                r_r <= writedata;
            if (w_byte && r_phase == 2'd1)
                r_g <= writedata;
            if (w_flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + AW'(1);
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            {VGA_R, VGA_G, VGA_B} <= w_pop ? r_mem[r_rp] : 24'd0;
            active <= w_slot;
            HSYNC  <= !((r_h >= 12'(H_ACTIVE + H_FP)) && (r_h < 12'(H_ACTIVE + H_FP + H_SYNC)));
            VSYNC  <= !((r_v >= 12'(V_ACTIVE + V_FP)) && (r_v < 12'(V_ACTIVE + V_FP + V_SYNC)));
            if (w_rd)
                readdata <= address ? {r_h, r_v}
                                    : {1'b0, r_state, r_phase, r_v >= 12'(V_ACTIVE), r_ovf, r_ufl, 11'd0, 5'(r_cnt)};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {r_r, r_g, writedata};
    end
endmodule

// File: tb/tb_vga_frame_writer.sv
// tb_vga_frame_writer: directed vectors and timed sequences for vga_frame_writer
// at reduced timing (8-clock lines, 5-line frames, 4-entry FIFO).
module tb_vga_frame_writer;
    logic        clk = 1'b0, reset = 1'b0, write = 1'b0, chipselect = 1'b0, address = 1'b0, read = 1'b0;
    logic [7:0]  writedata = 8'd0;
    logic [23:0] readdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        HSYNC, VSYNC, active;
    int          n = 0, passed = 0, total = 0;
    logic [24:0] pix_log [40];

    typedef struct {
        logic        wr;
        logic        rd;
        logic        a;
        logic [7:0]  d;
        logic        chk;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[$];

    localparam logic [23:0] VB_MASK = ~24'h040000;

    vga_frame_writer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write),
        .chipselect(chipselect), .address(address), .read(read), .readdata(readdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .active(active)
    );

    always #5 clk = ~clk;

    // n = rising edges since reset release, so the DUT counters should sit at h=n%8, v=(n/8)%5
    always @(posedge clk or negedge reset)
        if (!reset) n <= 0;
        else n <= n + 1;

    always @(negedge clk)
        pix_log[n % 40] <= {active, VGA_R, VGA_G, VGA_B};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({HSYNC, VSYNC, active, VGA_R, VGA_G, VGA_B});
    endfunction

    function automatic logic [63:0] exp_out(input logic hs, input logic vs, input logic act, input logic [23:0] rgb);
        return 64'({hs, vs, act, rgb});
    endfunction

    task automatic bus(input logic w, input logic r, input logic a, input logic [7:0] d);
        @(negedge clk);
        chipselect = w | r;
        write = w;
        read = r;
        address = a;
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write = 1'b0;
        read = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_check(input string name, input logic a, input logic [23:0] mask, input logic [23:0] exp);
        bus(1'b0, 1'b1, a, 8'd0);
        check(name, 64'(readdata & mask), 64'(exp));
    endtask

    task automatic wait_to(input int k);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (n % 40 != k && i < 100);
        if (n % 40 != k) begin
            total++;
            $display("FAIL wait_to: frame position %0d, wanted %0d", n % 40, k);
        end
    endtask

    task automatic chk_log(input string name, input int k, input logic [24:0] e);
        check(name, 64'(pix_log[k]), 64'(e));
    endtask

    task automatic add(input logic w, input logic r, input logic a, input logic [7:0] d, input logic c, input logic [23:0] e);
        vecs.push_back('{wr: w, rd: r, a: a, d: d, chk: c, exp: e});
    endtask

    initial begin
        logic hs_e, vs_e;
        int hs_low, vs_low;
        // flush mid-pixel, then fill to full and overflow, then clear flags
        add(1, 0, 0, 8'hEE, 0, 0);
        add(1, 0, 0, 8'hEF, 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h100000);
        add(1, 0, 1, 8'h04, 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h000000);
        for (int b = 1; b <= 3; b++) add(1, 0, 0, 8'(b), 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h000001);
        for (int b = 4; b <= 12; b++) add(1, 0, 0, 8'(b), 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h000004);
        add(1, 0, 0, 8'hD0, 0, 0);
        add(1, 0, 0, 8'hD1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h100004);
        add(1, 0, 0, 8'hD2, 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h020004);
        for (int b = 8'hD3; b <= 8'hDB; b++) add(1, 0, 0, 8'(b), 0, 0);
        add(0, 1, 0, 8'h00, 1, 24'h020004);
        add(1, 1, 1, 8'h02, 1, 24'h020004);
        add(0, 1, 0, 8'h00, 1, 24'h000004);

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), exp_out(1'b1, 1'b1, 1'b0, 24'h0));
        check("reset_readdata", 64'(readdata), 64'(24'h0));
        reset = 1'b1;

        hs_low = 0;
        vs_low = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            hs_e = !(((n - 1) % 8) inside {5, 6});
            vs_e = (((n - 1) / 8) % 5) != 3;
            check("idle_outputs", outs(), exp_out(hs_e, vs_e, 1'b0, 24'h0));
            hs_low += int'(!HSYNC);
            vs_low += int'(!VSYNC);
        end
        check("hsync_low_clocks", 64'(hs_low), 64'(20));
        check("vsync_low_clocks", 64'(vs_low), 64'(16));

        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        wr(1, 8'h01);
        rd_check("armed_status", 0, VB_MASK, 24'h200001);
        wait_to(1);
        check("first_pixel", outs(), exp_out(1'b1, 1'b1, 1'b1, 24'h112233));
        for (int s = 2; s <= 4; s++) begin
            @(negedge clk);
            check("underflow_slot", outs(), exp_out(1'b1, 1'b1, 1'b1, 24'h0));
        end
        rd_check("stream_status", 0, 24'hFFFFFF, 24'h410000);

        wait_to(20);
        wr(0, 8'hA1);
        wr(0, 8'hA2);
        wr(0, 8'hA3);
        wr(0, 8'hB1);
        wr(0, 8'hB2);
        wr(0, 8'hB3);
        rd_check("blanking_status", 0, 24'hFFFFFF, 24'h450002);
        wait_to(0);
        wr(1, 8'h00);
        wait_to(14);
        chk_log("drain_a", 1, 25'h1A1A2A3);
        chk_log("drain_b", 2, 25'h1B1B2B3);
        chk_log("drain_black", 3, 25'h1000000);
        chk_log("inactive_h4", 5, 25'h0);
        chk_log("line1_slot0", 9, 25'h1000000);
        chk_log("line1_slot3", 12, 25'h1000000);
        rd_check("frame_completes", 0, 24'hFFFFFF, 24'h410000);
        wait_to(6);
        for (int k = 1; k <= 4; k++) chk_log("after_disable", k, 25'h0);
        rd_check("idle_status", 0, 24'hFFFFFF, 24'h010000);

        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (vecs[i]) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) check($sformatf("vec%0d", i), 64'(readdata & VB_MASK), 64'(vecs[i].exp));
        end

        wr(1, 8'h01);
        rd_check("armed_full", 0, VB_MASK, 24'h200004);
        wait_to(1);
        wait_to(6);
        chk_log("kept_px0", 1, 25'h1010203);
        chk_log("kept_px1", 2, 25'h1040506);
        chk_log("kept_px2", 3, 25'h1070809);
        chk_log("kept_px3", 4, 25'h10A0B0C);
        wr(1, 8'h00);

        wait_to(2);
        for (int b = 0; b < 6; b++) wr(0, 8'h40 + 8'(b));
        rd_check("queued_two", 0, VB_MASK, 24'h010002);
        wait_to(11);
        reset = 1'b0;
        #1;
        check("midframe_reset_outputs", outs(), exp_out(1'b1, 1'b1, 1'b0, 24'h0));
        check("midframe_reset_readdata", 64'(readdata), 64'(24'h0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_check("restart_position", 1, 24'hFFFFFF, 24'h001000);
        rd_check("restart_status", 0, 24'hFFFFFF, 24'h000000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
